mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Multicycle control unit for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the ALU operation code plus all datapath enables and mux selects. It consumes the ALU `zero` flag to resolve branches. It sits between the instruction register (opcode/funct fields) and the shared datapath (register file, ALU, memory port, PC).

## Interface
Parameters:
- `MEM_WAIT_MAX`, default 15: cycles a memory state may wait on `mem_ready` before `mem_timeout` is raised.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  6  IR[31:26], valid from DECODE onward
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag, sampled in BRANCH
- `mem_ready`  in  1  memory access completes this cycle
- `alu_control`  out  4  ALU op code
- `alu_src_a`  out  1  0 = PC, 1 = reg A
- `alu_src_b`  out  2  00 reg B, 01 const 4, 10 imm, 11 imm<<2
- `imm_zext`  out  1  1 = zero-extend immediate (andi/ori)
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut
- `mem_read` / `mem_write`  out  1 each  memory strobes
- `ir_write`  out  1  latch instruction
- `reg_dst`  out  1  write register: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  write data: 0 = ALUOut, 1 = MDR
- `reg_write`  out  1  register file write enable
- `pc_src`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `pc_en`  out  1  PC load (unconditional or branch-taken)
- `instr_done`  out  1  one-cycle pulse in the last state of each instruction
- `illegal`  out  1  one-cycle pulse on an unsupported opcode/funct
- `mem_timeout`  out  1  sticky; cleared only by reset

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BRANCH, JUMP.
- FETCH: `iord`=0, `mem_read`=1, `alu_src_a`=0, `alu_src_b`=01, ADD, `pc_src`=00.
  - While `mem_ready`=0: hold, with `ir_write`=0 and `pc_en`=0.
  - On `mem_ready`=1: `ir_write`=1, `pc_en`=1, go to DECODE.
- DECODE: ADD, `alu_src_a`=0, `alu_src_b`=11 (branch target into ALUOut). Next state by opcode:
  - lw 100011 / sw 101011 → MEMADR
  - R-type 000000 → REX
  - addi 001000, andi 001100, ori 001101, slti 001010 → IEX
  - beq 000100 / bne 000101 → BRANCH
  - j 000010 → JUMP
  - otherwise: pulse `illegal`, go to FETCH
- MEMADR: ADD, `alu_src_a`=1, `alu_src_b`=10. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1, `mem_read`=1; waits on `mem_ready`, then MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1.
- MEMWR: `iord`=1, `mem_write`=1 held until `mem_ready`; then `instr_done`=1, go to FETCH.
- REX: `alu_src_a`=1, `alu_src_b`=00. `alu_control` from funct:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR
  - any other funct: pulse `illegal`, skip RWB, return to FETCH
- RWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1.
- IEX: `alu_src_a`=1, `alu_src_b`=10, `imm_zext`=1 for andi/ori. Op: ADD / AND / OR / SLT by opcode.
- IWB: `reg_write`=1, `reg_dst`=0, `instr_done`=1.
- BRANCH: SUB, `alu_src_a`=1, `alu_src_b`=00, `pc_src`=01.
  - `pc_en` = `zero` for beq, `~zero` for bne.
  - `instr_done`=1.
- JUMP: `pc_src`=10, `pc_en`=1, `instr_done`=1.
- After every final state the FSM returns to FETCH.
- Default for every output not listed in a state: 0, except `alu_control`, which defaults to ADD.

## Timing
- Reset: state = FETCH. Outputs take FETCH values: `mem_read`=1, `alu_src_b`=01, `alu_control`=0010, all others 0. `mem_timeout`=0.
- Outputs are Moore functions of the state. Exception: `pc_en` and `ir_write` in FETCH, and `pc_en` in BRANCH, also depend on the current-cycle input.
- Latency with `mem_ready` tied to 1:
  - lw: 5 cycles
  - sw, R-type, I-type: 4 cycles
  - beq/bne, j: 3 cycles
  - each cycle with `mem_ready`=0 adds one cycle
- Wait counter: 4 bits. It resets on entry to each memory state.
  - Reaching `MEM_WAIT_MAX` sets `mem_timeout`.
  - The FSM keeps waiting; the access is not aborted.
- Reset asserted mid-instruction: immediate return to FETCH. No `reg_write` or `mem_write` is issued after reset asserts.

## Structure
- Package `mips_ctrl_pkg`: ALU op localparams, opcode/funct constants, state enum, `alu_src_b` and `pc_src` encodings.
- One natural sub-module, `alu_op_decode` (combinational): maps state, opcode and funct to `alu_control` and a funct-illegal flag.

## Test plan
- Reset mid-REX → next cycle state FETCH, `mem_read`=1, `alu_control`=0010, `reg_write`=0.
- R-type funct 100010, `mem_ready`=1 → REX `alu_control`=0110; RWB `reg_write`=1 and `reg_dst`=1; `instr_done` in cycle 4.
- beq with `zero`=1 → BRANCH `pc_en`=1, `pc_src`=01. bne with `zero`=1 → `pc_en`=0.
- lw with `mem_ready` low for 3 cycles in MEMRD → `instr_done` in cycle 8, `mem_to_reg`=1.
- Opcode 111111 → `illegal` pulses in DECODE, FETCH next cycle, no `reg_write`. R-type funct 000001 → `illegal` in REX.
- `mem_ready` held low 16 cycles in FETCH → `mem_timeout`=1, stays 1 after completion until reset.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS control unit
package mips_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_REX, S_RWB, S_IEX, S_IWB, S_BRANCH, S_JUMP
  } state_t;

  // States that wait on mem_ready and therefore feed the timeout counter.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - ALU operation select from state, opcode and funct
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  output logic [3:0]  o_alu_control,
  output logic        o_funct_illegal
);

  always_comb begin
    o_alu_control   = ALU_ADD;
    o_funct_illegal = 1'b0;
    case (i_state)
      S_REX: begin
        case (i_funct)
          FN_ADD:  o_alu_control = ALU_ADD;
          FN_SUB:  o_alu_control = ALU_SUB;
          FN_AND:  o_alu_control = ALU_AND;
          FN_OR:   o_alu_control = ALU_OR;
          FN_SLT:  o_alu_control = ALU_SLT;
          FN_NOR:  o_alu_control = ALU_NOR;
          default: o_funct_illegal = 1'b1;
        endcase
      end
      S_IEX: begin
        case (i_opcode)
          OP_ANDI: o_alu_control = ALU_AND;
          OP_ORI:  o_alu_control = ALU_OR;
          OP_SLTI: o_alu_control = ALU_SLT;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      S_BRANCH: o_alu_control = ALU_SUB;
      default:  o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with memory-wait timeout
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  alu_control,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        imm_zext,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic [1:0]  pc_src,
  output logic        pc_en,
  output logic        instr_done,
  output logic        illegal,
  output logic        mem_timeout
);

  localparam logic [4:0] WAIT_LIMIT = 5'(MEM_WAIT_MAX);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_wait_cnt;
  logic        r_mem_timeout;
  logic [3:0]  w_alu_control;
  logic        w_funct_illegal;
  logic        w_waiting;
  logic [4:0]  w_wait_inc;

  alu_op_decode u_alu_op_decode (
    .i_state         (r_state),
    .i_opcode        (opcode),
    .i_funct         (funct),
    .o_alu_control   (w_alu_control),
    .o_funct_illegal (w_funct_illegal)
  );

  assign w_waiting   = is_mem_state(r_state) && !mem_ready;
  assign w_wait_inc  = {1'b0, r_wait_cnt} + 5'd1;
  assign mem_timeout = r_mem_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Memory states only exit on mem_ready, so clearing on any non-wait cycle
  // restarts the count on entry to every memory state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt    <= 4'd0;
      r_mem_timeout <= 1'b0;
    end else if (w_waiting) begin
      if (r_wait_cnt != 4'hF) begin
        r_wait_cnt <= w_wait_inc[3:0];
      end
      if (w_wait_inc >= WAIT_LIMIT) begin
        r_mem_timeout <= 1'b1;
      end
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end

  always_comb begin
    w_next      = r_state;
    alu_control = w_alu_control;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REGB;
    imm_zext    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    pc_src      = PCSRC_ALU;
    pc_en       = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW:                      w_next = S_MEMADR;
          OP_RTYPE:                          w_next = S_REX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_IEX;
          OP_BEQ, OP_BNE:                    w_next = S_BRANCH;
          OP_J:                              w_next = S_JUMP;
          default: begin
            illegal = 1'b1;
            w_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_REX: begin
        alu_src_a = 1'b1;
        if (w_funct_illegal) begin
          illegal = 1'b1;
          w_next  = S_FETCH;
        end else begin
          w_next  = S_RWB;
        end
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_IEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        imm_zext  = (opcode == OP_ANDI) || (opcode == OP_ORI);
        w_next    = S_IWB;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        pc_src     = PCSRC_ALUOUT;
        pc_en      = (opcode == OP_BNE) ? !zero : zero;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule
